elevator_look_ctrl: RTL and testbench
=====================================

// Module: elevator_look_ctrl
// PURPOSE
//  Parametrised single-car elevator controller; successor to the fixed 8-floor controller.
//  Latches hall and cab calls, schedules them with LOOK (serve all calls in the current direction, then reverse).
//  Sequences motor, door, door timers, obstruction and overload handling.
//  Sits between the button/sensor front end and the motor/door drivers; one car per instance.
// PARAMETERS
//  FLOORS            8   number of floors, 2..64
//  LVL_W             3   level_display width, >= clog2(FLOORS)
//  TRAVEL_CYCLES     4   clk cycles to travel one floor, >= 1
//  DOOR_OPEN_CYCLES  6   dwell cycles with door open, >= 1
//  DOOR_CLOSE_CYCLES 2   cycles for door closing motion, >= 1
//  PARK_FLOOR        0   home floor (ELEVATOR_PARK_EN only)
//  PARK_TIMEOUT      32  idle cycles before parking (ELEVATOR_PARK_EN only)
// PORTS
//  clk            in   1         system clock, rising edge
//  reset          in   1         asynchronous, active-high reset
//  open_btn       in   1         cab door-open request (level)
//  close_btn      in   1         cab door-close request (level)
//  overload       in   1         load over limit; blocks closing
//  sensor_inside  in   1         door-path obstruction
//  btn_in         in   FLOORS    cab calls, bit f = floor f
//  btn_up_out     in   FLOORS    hall up calls (bit FLOORS-1 ignored)
//  btn_down_out   in   FLOORS    hall down calls (bit 0 ignored)
//  engine         out  2         00 stop, 01 up, 10 down (11 never driven)
//  door           out  2         00 closed, 01 open, 10 closing
//  level_display  out  LVL_W     current floor, binary
//  dir_display    out  2         00 none, 01 up, 10 down (committed direction)
//  pending        out  FLOORS    OR of all latched calls per floor
// BEHAVIOUR
//  Reset: engine=00, door=00, level_display=0, dir_display=00, pending=0, all call latches clear, state IDLE.
//   Reset mid-move also returns the level to 0; there is no position recovery.
//  All outputs are registered. A button high at edge N sets its latch at N.
//   The FSM acts on the latches from edge N+1. Held buttons re-set the latch each cycle (idempotent).
//  Call latches: req_in, req_up, req_dn. A call for the current floor is not latched while door != 00.
//   Instead it reloads the dwell timer, or reopens a closing door.
//  FSM states: IDLE, MOVE, DOOR_OPEN, DOOR_CLOSE.
//  IDLE:
//   - any call at current floor -> DOOR_OPEN, door=01; open_btn also -> DOOR_OPEN.
//   - else calls ahead in dir_display -> MOVE in that direction.
//   - else calls in the other direction -> reverse and MOVE.
//   - else, dir=00, calls above -> up, calls below -> down (up wins on a tie).
//   - no calls -> stay, dir_display=00.
//  MOVE: engine=dir. Travel counter counts TRAVEL_CYCLES; on expiry level_display +/-1, counter reloads.
//   Stop at new floor f if any of:
//    - req_in[f];
//    - req_up[f] while going up, or req_dn[f] while going down;
//    - no calls beyond f in the current direction.
//   On stop, the same edge sets engine=00, door=01, state DOOR_OPEN.
//   Never moves past floor 0 or FLOORS-1; the last-floor condition forces a stop.
//  DOOR_OPEN: on entry clear req_in[f] and the hall latch matching the direction.
//   If no calls remain beyond f, clear both hall latches at f and, for the next trip, reverse dir (or set dir=00).
//   Dwell counter loads DOOR_OPEN_CYCLES; open_btn reloads it.
//   close_btn ends dwell next edge; overload holds the door open with the counter frozen.
//   Expiry -> DOOR_CLOSE, door=10.
//  DOOR_CLOSE: counts DOOR_CLOSE_CYCLES.
//   sensor_inside, open_btn, or a same-floor call -> DOOR_OPEN with dwell reloaded.
//   Expiry -> door=00, IDLE.
//  Simultaneous events: the reopen condition beats close_btn; overload beats close_btn.
//   Reopen beats DOOR_CLOSE expiry in the same cycle. New calls beyond the stop made in the stop cycle still count.
//  Engine is never nonzero while door != 00; door never leaves 00 while engine != 00.
// CONFIGURATION
//  ELEVATOR_PARK_EN defined:
//   - IDLE with no calls and dir_display=00 counts PARK_TIMEOUT cycles.
//   - Expiry issues an internal call to PARK_FLOOR; the door stays closed at arrival.
//   - Any button press or reset clears the count; a real call during the park trip is served normally.
//  Not defined: no park counter; the car stays at its last floor indefinitely.
// TESTING (FLOORS=8, TRAVEL=4, OPEN=6, CLOSE=2, park off unless noted)
//  1. Reset, btn_in[7] pulse at floor 0 -> engine=01 for 28 cycles, level 0..7 -> engine=00, door=01 for 6 cycles, door=10 for 2, door=00, dir=00.
//  2. At floor 0, btn_in[7] then btn_up_out[3] after 2 cycles -> stop at 3, door cycle, continue to 7; pending[3] clears on door open.
//  3. At 7 going down, btn_up_out[2] + btn_down_out[5] -> stop at 5; at 2, dir reverses to up at the door and the up latch clears.
//  4. Door closing, sensor_inside pulse -> door=01 next edge, 6-cycle dwell restarts; overload held 20 cycles -> door stays 01 throughout.
//  5. Reset asserted mid-move at level 4 -> all outputs 0 immediately; after release a btn_in[2] press -> move up from 0 to 2.
//  6. ELEVATOR_PARK_EN, PARK_FLOOR=0, idle at 6 for 32 cycles -> engine=10 to level 0, door stays 00; without macro -> stays at 6.

Source files
------------

// File: rtl/elevator_look_ctrl.sv
// elevator_look_ctrl -- single-car elevator controller with LOOK scheduling.
//   Latches cab and hall calls, serves every call in the committed direction
//   before reversing, and sequences motor, door, dwell/close timers,
//   obstruction and overload handling. All outputs are registered.
// Optional feature: define ELEVATOR_PARK_EN to send an idle car back to
//   PARK_FLOOR after PARK_TIMEOUT quiet cycles (door stays closed on arrival).
// Ports:
//   clk, reset        rising-edge clock, async active-high reset
//   open_btn          cab door-open (level)     close_btn  cab door-close (level)
//   overload          holds the door open       sensor_inside  door-path obstruction
//   btn_in            cab calls                 btn_up_out / btn_down_out  hall calls
//   engine            00 stop, 01 up, 10 down   door  00 closed, 01 open, 10 closing
//   level_display     current floor             dir_display  committed direction
//   pending           OR of latched calls per floor
module elevator_look_ctrl #(
  parameter int FLOORS            = 8,
  parameter int LVL_W             = 3,
  parameter int TRAVEL_CYCLES     = 4,
  parameter int DOOR_OPEN_CYCLES  = 6,
  parameter int DOOR_CLOSE_CYCLES = 2,
  parameter int PARK_FLOOR        = 0,
  parameter int PARK_TIMEOUT      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              open_btn,
  input  logic              close_btn,
  input  logic              overload,
  input  logic              sensor_inside,
  input  logic [FLOORS-1:0] btn_in,
  input  logic [FLOORS-1:0] btn_up_out,
  input  logic [FLOORS-1:0] btn_down_out,
  output logic [1:0]        engine,
  output logic [1:0]        door,
  output logic [LVL_W-1:0]  level_display,
  output logic [1:0]        dir_display,
  output logic [FLOORS-1:0] pending
);
  localparam logic [1:0] D_NONE = 2'b00, D_UP = 2'b01, D_DN = 2'b10;
  localparam logic [1:0] DR_CLOSED = 2'b00, DR_OPEN = 2'b01, DR_CLOSING = 2'b10;
  localparam int CNT_MAX = (TRAVEL_CYCLES > DOOR_OPEN_CYCLES)
    ? ((TRAVEL_CYCLES > DOOR_CLOSE_CYCLES) ? TRAVEL_CYCLES : DOOR_CLOSE_CYCLES)
    : ((DOOR_OPEN_CYCLES > DOOR_CLOSE_CYCLES) ? DOOR_OPEN_CYCLES : DOOR_CLOSE_CYCLES);
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  // Top floor has no up call, bottom floor no down call.
  localparam logic [FLOORS-1:0] UP_OK = {1'b0, {(FLOORS-1){1'b1}}};
  localparam logic [FLOORS-1:0] DN_OK = {{(FLOORS-1){1'b1}}, 1'b0};

  if (FLOORS < 2 || FLOORS > 64 || (1 << LVL_W) < FLOORS || TRAVEL_CYCLES < 1 ||
      DOOR_OPEN_CYCLES < 1 || DOOR_CLOSE_CYCLES < 1 || PARK_FLOOR < 0 ||
      PARK_FLOOR >= FLOORS || PARK_TIMEOUT < 1) begin : g_bad_cfg
    $error("elevator_look_ctrl: illegal parameter set");
  end

  typedef enum logic [1:0] {IDLE, MOVE, DOOR_OPEN, DOOR_CLOSE} state_t;

  function automatic logic [FLOORS-1:0] above_mask(input logic [LVL_W-1:0] f);
    logic [FLOORS-1:0] m;
    for (int i = 0; i < FLOORS; i++) m[i] = (i > int'(f));
    return m;
  endfunction
  function automatic logic [FLOORS-1:0] below_mask(input logic [LVL_W-1:0] f);
    logic [FLOORS-1:0] m;
    for (int i = 0; i < FLOORS; i++) m[i] = (i < int'(f));
    return m;
  endfunction
  function automatic logic [FLOORS-1:0] onehot(input logic [LVL_W-1:0] f);
    logic [FLOORS-1:0] m;
    for (int i = 0; i < FLOORS; i++) m[i] = (i == int'(f));
    return m;
  endfunction

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [1:0]         engine_n, door_n, dir_n, mv;
  logic [LVL_W-1:0]   lvl_n, f_tgt;
  logic [FLOORS-1:0]  req_in, req_up, req_dn, req_in_n, req_up_n, req_dn_n;
  logic [FLOORS-1:0]  clr_in, clr_up, clr_dn, set_in, set_up, set_dn, blk;
  logic [FLOORS-1:0]  cur_oh, f_oh, calls, calls_nx, park_vec;
  logic               same_call, entry, a_lat, b_lat, a_nx, b_nx;
  logic               ahead, behind, opp_hall, same_hall, stop_here;

  // A call for the floor the door is serving is not latched; it only
  // extends or reopens the door.
  assign cur_oh    = onehot(level_display);
  assign blk       = (door != DR_CLOSED) ? cur_oh : '0;
  assign set_in    = btn_in & ~blk;
  assign set_up    = btn_up_out & UP_OK & ~blk;
  assign set_dn    = btn_down_out & DN_OK & ~blk;
  assign same_call = (door != DR_CLOSED) &&
                     |((btn_in | (btn_up_out & UP_OK) | (btn_down_out & DN_OK)) & cur_oh);
  assign calls     = req_in | req_up | req_dn;
  // Calls pressed in the stop cycle count toward the "anything beyond" test.
  assign calls_nx  = calls | set_in | set_up | set_dn;

  // Floor being evaluated: the next floor while moving, else the current one.
  assign f_tgt = (state != MOVE) ? level_display :
                 (dir_display == D_DN) ? level_display - LVL_W'(1) : level_display + LVL_W'(1);
  assign f_oh  = onehot(f_tgt);
  // IDLE decides on latched calls only; stop/entry decisions use calls_nx.
  assign a_lat = |((calls | park_vec) & above_mask(level_display));
  assign b_lat = |((calls | park_vec) & below_mask(level_display));
  assign a_nx  = |((calls_nx | park_vec) & above_mask(f_tgt));
  assign b_nx  = |((calls_nx | park_vec) & below_mask(f_tgt));
  assign ahead  = (dir_display == D_UP) ? a_nx : (dir_display == D_DN) ? b_nx : 1'b0;
  assign behind = (dir_display == D_UP) ? b_nx : (dir_display == D_DN) ? a_nx : 1'b0;
  assign same_hall = (dir_display == D_UP) ? |((req_up | set_up) & f_oh) :
                     (dir_display == D_DN) ? |((req_dn | set_dn) & f_oh) : 1'b0;
  assign opp_hall  = (dir_display == D_UP) ? |((req_dn | set_dn) & f_oh) :
                     (dir_display == D_DN) ? |((req_up | set_up) & f_oh) : 1'b0;
  assign stop_here = |((req_in | set_in) & f_oh) || same_hall || !ahead;

`ifdef ELEVATOR_PARK_EN
  localparam logic [LVL_W-1:0] PARK_LVL = LVL_W'(PARK_FLOOR);
  localparam int PW = $clog2(PARK_TIMEOUT + 1);
  logic [PW-1:0] park_cnt;
  logic          park_act, park_clr, any_call, park_quiet;
  assign any_call   = |(btn_in | (btn_up_out & UP_OK) | (btn_down_out & DN_OK));
  assign park_vec   = park_act ? onehot(PARK_LVL) : '0;
  assign park_quiet = (state == IDLE) && (calls == '0) && (dir_display == D_NONE);

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      park_cnt <= '0;
      park_act <= 1'b0;
    end else begin
      if (any_call || park_clr) park_act <= 1'b0;
      if (any_call || open_btn || close_btn || !park_quiet || park_act) park_cnt <= '0;
      else if (park_cnt == PW'(PARK_TIMEOUT - 1)) begin
        park_cnt <= '0;
        park_act <= (level_display != PARK_LVL);  // already home: nothing to do
      end else park_cnt <= park_cnt + 1'b1;
    end
`else
  assign park_vec = '0;
`endif

  always_comb begin
    state_n = state; engine_n = engine; door_n = door; lvl_n = level_display;
    dir_n = dir_display; cnt_n = cnt; mv = D_NONE; entry = 1'b0;
    clr_in = '0; clr_up = '0; clr_dn = '0;
`ifdef ELEVATOR_PARK_EN
    park_clr = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (|(calls & cur_oh) || open_btn) entry = 1'b1;
        // Keep going the committed way; up wins when uncommitted.
        else if (a_lat && !(dir_display == D_DN && b_lat)) mv = D_UP;
        else if (b_lat) mv = D_DN;
        else dir_n = D_NONE;
        if (mv != D_NONE) begin
          state_n = MOVE; engine_n = mv; dir_n = mv; cnt_n = CNT_W'(TRAVEL_CYCLES - 1);
        end
      end
      MOVE: begin
        if (cnt != '0) cnt_n = cnt - 1'b1;
        else begin
          lvl_n = f_tgt;
          cnt_n = CNT_W'(TRAVEL_CYCLES - 1);
`ifdef ELEVATOR_PARK_EN
          if (park_act && !any_call && f_tgt == PARK_LVL) begin
            state_n = IDLE; engine_n = D_NONE; dir_n = D_NONE; park_clr = 1'b1;
          end else
`endif
          if (stop_here) entry = 1'b1;
        end
      end
      DOOR_OPEN: begin
        if (open_btn || same_call) cnt_n = CNT_W'(DOOR_OPEN_CYCLES - 1);
        else if (overload) cnt_n = cnt;  // held open, timer frozen
        else if (close_btn || cnt == '0) begin
          state_n = DOOR_CLOSE; door_n = DR_CLOSING; cnt_n = CNT_W'(DOOR_CLOSE_CYCLES - 1);
        end else cnt_n = cnt - 1'b1;
      end
      DOOR_CLOSE: begin
        if (sensor_inside || open_btn || same_call || overload) begin
          state_n = DOOR_OPEN; door_n = DR_OPEN; cnt_n = CNT_W'(DOOR_OPEN_CYCLES - 1);
        end else if (cnt == '0) begin
          state_n = IDLE; door_n = DR_CLOSED;
        end else cnt_n = cnt - 1'b1;
      end
      default: state_n = IDLE;
    endcase

    // Door-open entry: retire the served calls and pick the next trip's direction.
    if (entry) begin
      state_n = DOOR_OPEN; engine_n = D_NONE; door_n = DR_OPEN;
      cnt_n = CNT_W'(DOOR_OPEN_CYCLES - 1);
      clr_in = f_oh;
      if (dir_display == D_UP) clr_up = f_oh;
      if (dir_display == D_DN) clr_dn = f_oh;
      if (!ahead) begin
        clr_up = f_oh; clr_dn = f_oh;
        dir_n = !(behind || opp_hall) ? D_NONE : (dir_display == D_UP) ? D_DN : D_UP;
      end
    end
  end

  assign req_in_n = (req_in | set_in) & ~clr_in;
  assign req_up_n = (req_up | set_up) & ~clr_up;
  assign req_dn_n = (req_dn | set_dn) & ~clr_dn;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE; cnt <= '0; engine <= D_NONE; door <= DR_CLOSED;
      level_display <= '0; dir_display <= D_NONE;
      req_in <= '0; req_up <= '0; req_dn <= '0; pending <= '0;
    end else begin
      state <= state_n; cnt <= cnt_n; engine <= engine_n; door <= door_n;
      level_display <= lvl_n; dir_display <= dir_n;
      req_in <= req_in_n; req_up <= req_up_n; req_dn <= req_dn_n;
      pending <= req_in_n | req_up_n | req_dn_n;
    end
endmodule

// File: tb/tb_elevator_look_ctrl.sv
// Directed bench for elevator_look_ctrl (8 floors, travel 4, open 6, close 2).
module tb_elevator_look_ctrl;
  logic       clk = 1'b0;
  logic       reset, open_btn, close_btn, overload, sensor_inside;
  logic [7:0] btn_in, btn_up_out, btn_down_out;
  logic [1:0] engine, door, dir_display;
  logic [2:0] level_display;
  logic [7:0] pending;
  int n_chk = 0, n_fail = 0;
  int n;

  always #5 clk = ~clk;

  elevator_look_ctrl #(
    .FLOORS(8), .LVL_W(3), .TRAVEL_CYCLES(4), .DOOR_OPEN_CYCLES(6),
    .DOOR_CLOSE_CYCLES(2), .PARK_FLOOR(0), .PARK_TIMEOUT(32)
  ) dut (
    .clk(clk), .reset(reset), .open_btn(open_btn), .close_btn(close_btn),
    .overload(overload), .sensor_inside(sensor_inside), .btn_in(btn_in),
    .btn_up_out(btn_up_out), .btn_down_out(btn_down_out), .engine(engine),
    .door(door), .level_display(level_display), .dir_display(dir_display),
    .pending(pending)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while ((door != 2'b00 || engine != 2'b00) && k < 200) begin step(1); k++; end
    chk(tag, (k < 200), 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; open_btn = 0; close_btn = 0; overload = 0; sensor_inside = 0;
    btn_in = 0; btn_up_out = 0; btn_down_out = 0;
    step(2);
    chk("rst_engine", engine, 2'b00);
    chk("rst_door", door, 2'b00);
    chk("rst_level", level_display, 0);
    chk("rst_dir", dir_display, 2'b00);
    chk("rst_pending", pending, 8'h00);
    reset = 1'b0;
    step(1);

    // 1: cab call to top floor from floor 0
    btn_in = 8'h80; step(1); btn_in = 0;
    chk("t1_pending", pending, 8'h80);
    chk("t1_engine_wait", engine, 2'b00);
    step(1);
    chk("t1_dir_up", dir_display, 2'b01);
    n = 0; while (engine == 2'b01 && n < 100) begin n++; step(1); end
    chk("t1_move_cycles", n, 28);
    chk("t1_level7", level_display, 7);
    chk("t1_door_open", door, 2'b01);
    n = 0; while (door == 2'b01 && n < 100) begin n++; step(1); end
    chk("t1_dwell_cycles", n, 6);
    chk("t1_door_closing", door, 2'b10);
    n = 0; while (door == 2'b10 && n < 100) begin n++; step(1); end
    chk("t1_close_cycles", n, 2);
    chk("t1_door_closed", door, 2'b00);
    chk("t1_dir_none", dir_display, 2'b00);
    chk("t1_pending_clr", pending, 8'h00);

    // 2: intermediate hall-up call picked up on the way
    do_reset();
    btn_in = 8'h80; step(1); btn_in = 0;
    step(1);
    btn_up_out = 8'h08; step(1); btn_up_out = 0;
    step(10);
    chk("t2_pending_both", pending, 8'h88);
    chk("t2_level2", level_display, 2);
    chk("t2_engine_up", engine, 2'b01);
    step(1);
    chk("t2_stop_level3", level_display, 3);
    chk("t2_stop_engine", engine, 2'b00);
    chk("t2_stop_door", door, 2'b01);
    chk("t2_pending3_clr", pending, 8'h80);
    chk("t2_dir_kept", dir_display, 2'b01);
    step(9);
    chk("t2_resume_engine", engine, 2'b01);
    step(16);
    chk("t2_level7", level_display, 7);
    chk("t2_door7", door, 2'b01);
    chk("t2_dir_none", dir_display, 2'b00);
    chk("t2_pending_none", pending, 8'h00);

    // 3: going down from 7, down call at 5, up call at 2
    wait_idle("t3_idle_wait");
    btn_up_out = 8'h04; btn_down_out = 8'h20; step(1);
    btn_up_out = 0; btn_down_out = 0;
    chk("t3_pending", pending, 8'h24);
    step(1);
    chk("t3_engine_down", engine, 2'b10);
    chk("t3_dir_down", dir_display, 2'b10);
    step(8);
    chk("t3_stop5", level_display, 5);
    chk("t3_door5", door, 2'b01);
    chk("t3_dir5", dir_display, 2'b10);
    chk("t3_pending5", pending, 8'h04);
    step(21);
    chk("t3_stop2", level_display, 2);
    chk("t3_door2", door, 2'b01);
    chk("t3_dir_rev_up", dir_display, 2'b01);
    chk("t3_pending2", pending, 8'h00);

    // 4: same-floor call, reopen, overload vs close_btn, close_btn
    step(2);
    btn_in = 8'h04; step(1); btn_in = 0;
    chk("t4_samefloor_unlatched", pending, 8'h00);
    step(5);
    chk("t4_dwell_reloaded", door, 2'b01);
    step(1);
    chk("t4_closing", door, 2'b10);
    sensor_inside = 1; step(1); sensor_inside = 0;
    chk("t4_sensor_reopen", door, 2'b01);
    close_btn = 1; overload = 1; step(1); close_btn = 0;
    chk("t4_overload_beats_close", door, 2'b01);
    n = 0;
    repeat (19) begin step(1); if (door == 2'b01) n++; end
    overload = 0;
    chk("t4_overload_hold", n, 19);
    step(5);
    chk("t4_dwell_resumes", door, 2'b01);
    step(1);
    chk("t4_closing2", door, 2'b10);
    open_btn = 1; step(1); open_btn = 0;
    chk("t4_open_btn_reopen", door, 2'b01);
    close_btn = 1; step(1); close_btn = 0;
    chk("t4_close_btn", door, 2'b10);
    step(2);
    chk("t4_closed", door, 2'b00);
    step(1);
    chk("t4_dir_none", dir_display, 2'b00);

    // 5: async reset mid-move, then a fresh trip from 0
    do_reset();
    btn_in = 8'h80; step(1); btn_in = 0;
    step(17);
    chk("t5_level4", level_display, 4);
    chk("t5_moving", engine, 2'b01);
    #2 reset = 1'b1;
    #1;
    chk("t5_rst_engine", engine, 2'b00);
    chk("t5_rst_level", level_display, 0);
    chk("t5_rst_dir", dir_display, 2'b00);
    chk("t5_rst_pending", pending, 8'h00);
    chk("t5_rst_door", door, 2'b00);
    step(1);
    reset = 1'b0;
    btn_in = 8'h04; step(1); btn_in = 0;
    step(1);
    chk("t5_engine_up", engine, 2'b01);
    step(8);
    chk("t5_level2", level_display, 2);
    chk("t5_door2", door, 2'b01);
    chk("t5_engine_stop", engine, 2'b00);

    // 6: long idle
    wait_idle("t6_idle_wait");
`ifdef ELEVATOR_PARK_EN
    n = 0; while (engine != 2'b10 && n < 100) begin n++; step(1); end
    chk("t6_park_start", engine, 2'b10);
    n = 0; while (engine != 2'b00 && n < 100) begin n++; if (door != 2'b00) n = 1000; step(1); end
    chk("t6_park_door_closed", (n < 100), 1);
    chk("t6_park_level", level_display, 0);
    step(3);
    chk("t6_park_door_stays", door, 2'b00);
`else
    step(40);
    chk("t6_stay_level", level_display, 2);
    chk("t6_stay_engine", engine, 2'b00);
    chk("t6_stay_door", door, 2'b00);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
